write_channel_native: RTL
=========================

# write_channel_native

Write-back channel of the cache back-end. When the cache evicts a dirty line, this block accepts the line address and the full line data in a single handshake and registers them. It then writes the line to the higher-hierarchy memory as a sequence of native-interface word writes. It is the write-direction counterpart of the line-fill read channel and shares the same native memory port style and the same line/word address split.

## Interface
Parameters:
- FE_ADDR_W, 32, front-end byte-address width
- FE_DATA_W, 32, front-end word width
- WORD_OFF_W, 3, log2 of front-end words per cache line
- BE_ADDR_W, FE_ADDR_W, back-end memory address width
- BE_DATA_W, FE_DATA_W, back-end memory word width
- BE_NBYTES, BE_DATA_W/8, bytes per back-end word
- BE_BYTE_W, $clog2(BE_NBYTES), byte-offset bits
- LINE2MEM_W, WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W), log2 of back-end words per line (≥0)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- write_valid  in  1  eviction request
- write_addr  in  FE_ADDR_W-BE_BYTE_W-LINE2MEM_W  line address, i.e. byte-address bits [FE_ADDR_W-1:BE_BYTE_W+LINE2MEM_W]
- write_line  in  (2**LINE2MEM_W)*BE_DATA_W  line data; word i is at bits [i*BE_DATA_W +: BE_DATA_W]
- write_ready  out  1  high when idle and able to accept a request
- mem_valid  out  1  native request valid
- mem_addr  out  BE_ADDR_W  byte address, zero-extended
- mem_wdata  out  BE_DATA_W  write data
- mem_wstrb  out  BE_NBYTES  byte strobes
- mem_ready  in  1  native acknowledge

## Operation
- There are two states: IDLE and WRITE. Reset forces IDLE, clears the word counter, and clears the address and data registers to 0.
- **IDLE**
  - Outputs: write_ready=1, mem_valid=0, mem_wstrb=0.
  - When write_valid=1, the block registers write_addr and write_line, sets counter=0, and moves to WRITE.
  - mem_ready is ignored in this state.
- **WRITE**
  - Outputs: write_ready=0, mem_valid=1, mem_wstrb=all ones.
  - mem_addr = {reg_addr, counter, BE_BYTE_W'b0}, zero-extended to BE_ADDR_W.
  - mem_wdata = reg_line word[counter].
  - On mem_ready=1:
    - If counter is all ones, the state returns to IDLE.
    - Otherwise counter increments by 1.
  - On mem_ready=0, all outputs hold stable.
- write_valid received in WRITE is ignored. The requester holds write_valid until it sees write_ready.
- The counter never wraps. The final word always exits to IDLE.
- LINE2MEM_W==0 case:
  - The counter does not exist.
  - mem_addr = {reg_addr, BE_BYTE_W'b0}.
  - The first mem_ready exits to IDLE.
- write_line is sampled only at acceptance. Changes after acceptance have no effect on the burst.

## Timing
- Outputs are combinational from state and registers only. There is no combinational path from mem_ready or write_valid to any output.
- Acceptance happens at edge E. mem_valid is high in the cycle after E, carrying word 0.
- Each mem_ready=1 cycle completes one word.
  - With mem_ready held high, a burst takes 2**LINE2MEM_W cycles.
  - write_ready is high in the cycle after the last ready.
  - Minimum turnaround between successive requests is 2**LINE2MEM_W+1 cycles.
- Native rule: once mem_valid rises, mem_valid, mem_addr, mem_wdata and mem_wstrb stay constant until the cycle in which mem_ready=1.
- Reset asserted mid-burst:
  - mem_valid falls and write_ready rises asynchronously.
  - The rest of the burst is discarded.
  - After reset is released, a new request starts again from word 0.

## Structure
- The IDLE/WRITE state encoding belongs in the shared cache header alongside the read-channel states.
- The LINE2MEM_W/BE_BYTE_W derivation expressions belong in the shared cache header so both channels use identical definitions.
- No sub-module. Word selection is an indexed part-select inside the block. The LINE2MEM_W==0 variant is a generate branch.

## Test plan
Default parameters give 8 words per line. Line address 0x80 corresponds to byte base 0x1000. Word i of the test line is 0xA0000000+i.
- **Reset:** reset=1 -> write_ready=1, mem_valid=0, mem_wstrb=0. Release reset with write_valid=0 -> no change.
- **Full-speed burst:** mem_ready held at 1, one request -> 8 consecutive cycles with mem_valid=1.
  - Addresses 0x1000, 0x1004, … 0x101C; data 0xA0000000 … 0xA0000007; wstrb=0xF.
  - write_ready=1 in the following cycle.
- **Backpressure:** mem_ready toggles 0,0,1 per word -> each word is held stable for 3 cycles. 24 cycles total, with no skipped or repeated words.
- **Busy request and line change:** write_valid kept high and write_line changed during the burst -> the second request is not accepted until write_ready=1. The first burst still writes the original data.
- **Mid-burst reset:** reset pulsed after word 3 -> mem_valid=0 immediately. The next request writes from 0x1000 (word 0).
- **LINE2MEM_W=0 build (WORD_OFF_W=0):** request with write_addr=0x400 -> one write to 0x1000, then write_ready=1.

Source files
------------

// File: rtl/write_channel_native_pkg.sv
// Shared cache back-end header.
// Holds the channel state encodings and the line/word address split helpers.
// Both the line-fill read channel and the write-back channel compute their
// derived widths from these functions, so the two cannot drift apart.
package write_channel_native_pkg;

   // Line-fill read channel states (kept here so both channels share one header).
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_FILL = 1'b1
   } rd_state_e;

   // Write-back channel states.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wr_state_e;

   // Byte-offset bits inside one back-end word.
   function automatic int be_byte_w(input int be_data_w);
      return $clog2(be_data_w / 8);
   endfunction

   // log2 of back-end words per cache line (0 when one back-end word holds the line).
   function automatic int line2mem_w(input int word_off_w, input int be_data_w,
                                     input int fe_data_w);
      return word_off_w - $clog2(be_data_w / fe_data_w);
   endfunction

endpackage

// File: rtl/write_channel_native_if.sv
// Bus bundle of the write-back channel: the eviction request side
// (write_valid/write_addr/write_line/write_ready) and the native memory side
// (mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_ready).
// Modports:
//   slave  - the write-back channel itself
//   master - the environment (cache front-end plus memory)
// Handshake semantics: a request transfers on a rising edge where
// write_valid=1 and write_ready=1; a memory word completes on a rising edge
// where mem_valid=1 and mem_ready=1, and mem_valid/mem_addr/mem_wdata/
// mem_wstrb hold constant from rise until that edge.
interface write_channel_native_if
   import write_channel_native_pkg::*;
#(
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int WORD_OFF_W = 3,
   parameter int BE_ADDR_W  = FE_ADDR_W,
   parameter int BE_DATA_W  = FE_DATA_W
);
   localparam int BE_NBYTES  = BE_DATA_W / 8;
   localparam int BE_BYTE_W  = be_byte_w(BE_DATA_W);
   localparam int LINE2MEM_W = line2mem_w(WORD_OFF_W, BE_DATA_W, FE_DATA_W);
   localparam int LADDR_W    = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;
   localparam int LINE_W     = (2 ** LINE2MEM_W) * BE_DATA_W;

   logic                 write_valid;
   logic [LADDR_W-1:0]   write_addr;
   logic [LINE_W-1:0]    write_line;
   logic                 write_ready;
   logic                 mem_valid;
   logic [BE_ADDR_W-1:0] mem_addr;
   logic [BE_DATA_W-1:0] mem_wdata;
   logic [BE_NBYTES-1:0] mem_wstrb;
   logic                 mem_ready;

   modport slave (
      input  write_valid, write_addr, write_line, mem_ready,
      output write_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output write_valid, write_addr, write_line, mem_ready,
      input  write_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/write_channel_native.sv
// Write-back channel of the cache back-end.
// Accepts an evicted dirty line (line address + full line data) in a single
// handshake, registers it, then writes it to memory as a burst of native
// word writes, lowest word first.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-high
//   bus     - write_channel_native_if.slave (request side + native memory side)
//   state_o - current FSM state (debug)
module write_channel_native
   import write_channel_native_pkg::*;
#(
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int WORD_OFF_W = 3,
   parameter int BE_ADDR_W  = FE_ADDR_W,
   parameter int BE_DATA_W  = FE_DATA_W,
   parameter int BE_NBYTES  = BE_DATA_W / 8,
   parameter int BE_BYTE_W  = be_byte_w(BE_DATA_W),
   parameter int LINE2MEM_W = line2mem_w(WORD_OFF_W, BE_DATA_W, FE_DATA_W)
) (
   input  logic                         clk,
   input  logic                         reset,
   write_channel_native_if.slave        bus,
   output wr_state_e                    state_o
);
   localparam int NWORDS  = 2 ** LINE2MEM_W;
   localparam int LADDR_W = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;

   wr_state_e                         state_q;
   logic [LADDR_W-1:0]                addr_q;
   logic [NWORDS-1:0][BE_DATA_W-1:0]  line_q;

   logic                              last_word;
   logic [FE_ADDR_W-1:0]              byte_addr;
   logic [BE_DATA_W-1:0]              word_sel;

   // Control FSM; the line is captured only at acceptance so later changes
   // on write_line cannot leak into a burst in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         line_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.write_valid) begin
                  addr_q  <= bus.write_addr;
                  line_q  <= bus.write_line;
                  state_q <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (bus.mem_ready && last_word) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   generate
      if (LINE2MEM_W > 0) begin : g_cnt
         logic [LINE2MEM_W-1:0] cnt_q;
         logic [LINE2MEM_W-1:0] cnt_d;

         // Counter saturates on the last word: that completion leaves WRITE
         // instead of wrapping, and the next acceptance restarts it at 0.
         always_comb begin
            cnt_d = cnt_q;
            if (state_q == ST_IDLE) begin
               if (bus.write_valid) cnt_d = '0;
            end else if (bus.mem_ready && !(&cnt_q)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
         end

         assign last_word = &cnt_q;
         assign word_sel  = line_q[cnt_q];
         assign byte_addr = FE_ADDR_W'({addr_q, cnt_q}) << BE_BYTE_W;
      end else begin : g_nocnt
         // Whole line is one back-end word: the first completion ends the burst.
         assign last_word = 1'b1;
         assign word_sel  = line_q[0];
         assign byte_addr = FE_ADDR_W'(addr_q) << BE_BYTE_W;
      end
   endgenerate

   // Outputs depend only on state and registers, never on mem_ready or
   // write_valid, so they stay stable while the memory stalls.
   assign bus.write_ready = (state_q == ST_IDLE);
   assign bus.mem_valid   = (state_q == ST_WRITE);
   assign bus.mem_wstrb   = (state_q == ST_WRITE) ? '1 : '0;
   assign bus.mem_addr    = BE_ADDR_W'(byte_addr);
   assign bus.mem_wdata   = word_sel;
   assign state_o         = state_q;

endmodule
